// File: rtl/video_pattern_gen_if.sv
// Video output bus from the test-pattern generator to the TX encoder.
interface video_pattern_gen_if #(
  parameter int DW = 8
);
  logic          vid_hs;
  logic          vid_vs;
  logic          vid_de;
  logic          vid_sof;
  logic [DW-1:0] vid_r;
  logic [DW-1:0] vid_g;
  logic [DW-1:0] vid_b;

  modport master (output vid_hs, vid_vs, vid_de, vid_sof, vid_r, vid_g, vid_b);
  modport slave  (input  vid_hs, vid_vs, vid_de, vid_sof, vid_r, vid_g, vid_b);
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing + test-pattern source with frame-boundary config shadowing and SOF/frame count.
// Optional macro VID_PATTERN_BORDER_EN blanks the outermost active pixels and lines.
module video_pattern_gen #(
  parameter int CW        = 12,
  parameter int DW        = 8,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int BAR_SHIFT = 4,
  parameter int CHK_SHIFT = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [3*DW-1:0]     solid_rgb,
  input  logic [CW-1:0]       h_total,
  input  logic [CW-1:0]       h_sync,
  input  logic [CW-1:0]       h_start,
  input  logic [CW-1:0]       h_end,
  input  logic [CW-1:0]       v_total,
  input  logic [CW-1:0]       v_sync,
  input  logic [CW-1:0]       v_start,
  input  logic [CW-1:0]       v_end,
  video_pattern_gen_if.master vid,
  output logic [7:0]          frame_cnt
);

  localparam logic          HS_IDLE  = (HS_POL == 0) ? 1'b1 : 1'b0;
  localparam logic          VS_IDLE  = (VS_POL == 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] C_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] PIX_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] PIX_ONES = {DW{1'b1}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_r;
  logic [CW-1:0]   h_cnt_r, v_cnt_r;
  logic [CW-1:0]   h_total_r, h_sync_r, h_start_r, h_end_r;
  logic [CW-1:0]   v_total_r, v_sync_r, v_start_r, v_end_r;
  logic [1:0]      mode_r;
  logic [3*DW-1:0] solid_r;

  logic            hs_p_r, vs_p_r, de_p_r, sof_p_r, bnd_p_r;
  logic [DW-1:0]   r_p_r, g_p_r, b_p_r;

  logic [CW-1:0]   x_s, y_s;
  logic [2:0]      bar_idx_s;
  logic            de_s, paint_s, sof_s, bnd_s, hs_s, vs_s, load_s, run_s;
  logic [DW-1:0]   r_s, g_s, b_s;

  // Position decode and pattern generation for the current counter position.
  always_comb begin
    x_s       = h_cnt_r - h_start_r;
    y_s       = v_cnt_r - v_start_r;
    de_s      = (h_cnt_r >= h_start_r) && (h_cnt_r < h_end_r) &&
                (v_cnt_r >= v_start_r) && (v_cnt_r < v_end_r);
    hs_s      = (h_cnt_r < h_sync_r) ? ~HS_IDLE : HS_IDLE;
    vs_s      = (v_cnt_r < v_sync_r) ? ~VS_IDLE : VS_IDLE;
    sof_s     = de_s && (x_s == C_ZERO) && (y_s == C_ZERO);
    bnd_s     = (h_cnt_r == h_total_r) && (v_cnt_r == v_total_r);
    run_s     = en && (state_r == ST_RUN);
    load_s    = en && ((state_r == ST_IDLE) || bnd_s);
    bar_idx_s = 3'(x_s >> BAR_SHIFT);
    r_s       = PIX_ZERO;
    g_s       = PIX_ZERO;
    b_s       = PIX_ZERO;
`ifdef VID_PATTERN_BORDER_EN
    paint_s   = de_s && !((x_s == C_ZERO) || (y_s == C_ZERO) ||
                          (x_s == h_end_r - h_start_r - C_ONE) ||
                          (y_s == v_end_r - v_start_r - C_ONE));
`else
    paint_s   = de_s;
`endif
    if (paint_s) begin
      case (mode_r)
        2'd0: begin
          r_s = DW'(x_s);
          g_s = DW'(x_s);
          b_s = DW'(x_s);
        end
        2'd1: begin
          r_s = {DW{~bar_idx_s[1]}};
          g_s = {DW{~bar_idx_s[2]}};
          b_s = {DW{~bar_idx_s[0]}};
        end
        2'd2: begin
          if (x_s[CHK_SHIFT] ^ y_s[CHK_SHIFT]) begin
            r_s = PIX_ONES;
            g_s = PIX_ONES;
            b_s = PIX_ONES;
          end else begin
            r_s = PIX_ZERO;
            g_s = PIX_ZERO;
            b_s = PIX_ZERO;
          end
        end
        2'd3: begin
          r_s = solid_r[3*DW-1:2*DW];
          g_s = solid_r[2*DW-1:DW];
          b_s = solid_r[DW-1:0];
        end
        default: begin
          r_s = PIX_ZERO;
          g_s = PIX_ZERO;
          b_s = PIX_ZERO;
        end
      endcase
    end else begin
      r_s = PIX_ZERO;
      g_s = PIX_ZERO;
      b_s = PIX_ZERO;
    end
  end

  // Run/idle FSM and raster counters; IDLE holds (0,0) for the first enabled cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      h_cnt_r <= C_ZERO;
      v_cnt_r <= C_ZERO;
    end else if (!en) begin
      state_r <= ST_IDLE;
      h_cnt_r <= C_ZERO;
      v_cnt_r <= C_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_RUN;
          h_cnt_r <= C_ZERO;
          v_cnt_r <= C_ZERO;
        end
        ST_RUN: begin
          if (h_cnt_r == h_total_r) begin
            h_cnt_r <= C_ZERO;
            v_cnt_r <= (v_cnt_r == v_total_r) ? C_ZERO : v_cnt_r + C_ONE;
          end else begin
            h_cnt_r <= h_cnt_r + C_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          h_cnt_r <= C_ZERO;
          v_cnt_r <= C_ZERO;
        end
      endcase
    end
  end

  // Configuration shadows, refreshed only on en rise and at the frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total_r <= C_ZERO;
      h_sync_r  <= C_ZERO;
      h_start_r <= C_ZERO;
      h_end_r   <= C_ZERO;
      v_total_r <= C_ZERO;
      v_sync_r  <= C_ZERO;
      v_start_r <= C_ZERO;
      v_end_r   <= C_ZERO;
      mode_r    <= 2'd0;
      solid_r   <= {(3*DW){1'b0}};
    end else if (load_s) begin
      h_total_r <= h_total;
      h_sync_r  <= h_sync;
      h_start_r <= h_start;
      h_end_r   <= h_end;
      v_total_r <= v_total;
      v_sync_r  <= v_sync;
      v_start_r <= v_start;
      v_end_r   <= v_end;
      mode_r    <= mode;
      solid_r   <= solid_rgb;
    end
  end

  // Two-stage output pipeline; flushed to idle whenever not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_p_r      <= HS_IDLE;
      vs_p_r      <= VS_IDLE;
      de_p_r      <= 1'b0;
      sof_p_r     <= 1'b0;
      bnd_p_r     <= 1'b0;
      r_p_r       <= PIX_ZERO;
      g_p_r       <= PIX_ZERO;
      b_p_r       <= PIX_ZERO;
      vid.vid_hs  <= HS_IDLE;
      vid.vid_vs  <= VS_IDLE;
      vid.vid_de  <= 1'b0;
      vid.vid_sof <= 1'b0;
      vid.vid_r   <= PIX_ZERO;
      vid.vid_g   <= PIX_ZERO;
      vid.vid_b   <= PIX_ZERO;
      frame_cnt   <= 8'd0;
    end else if (!run_s) begin
      hs_p_r      <= HS_IDLE;
      vs_p_r      <= VS_IDLE;
      de_p_r      <= 1'b0;
      sof_p_r     <= 1'b0;
      bnd_p_r     <= 1'b0;
      r_p_r       <= PIX_ZERO;
      g_p_r       <= PIX_ZERO;
      b_p_r       <= PIX_ZERO;
      vid.vid_hs  <= HS_IDLE;
      vid.vid_vs  <= VS_IDLE;
      vid.vid_de  <= 1'b0;
      vid.vid_sof <= 1'b0;
      vid.vid_r   <= PIX_ZERO;
      vid.vid_g   <= PIX_ZERO;
      vid.vid_b   <= PIX_ZERO;
      frame_cnt   <= 8'd0;
    end else begin
      hs_p_r      <= hs_s;
      vs_p_r      <= vs_s;
      de_p_r      <= de_s;
      sof_p_r     <= sof_s;
      bnd_p_r     <= bnd_s;
      r_p_r       <= r_s;
      g_p_r       <= g_s;
      b_p_r       <= b_s;
      vid.vid_hs  <= hs_p_r;
      vid.vid_vs  <= vs_p_r;
      vid.vid_de  <= de_p_r;
      vid.vid_sof <= sof_p_r;
      vid.vid_r   <= r_p_r;
      vid.vid_g   <= g_p_r;
      vid.vid_b   <= b_p_r;
      frame_cnt   <= frame_cnt + {7'd0, bnd_p_r};
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed self-checking bench for video_pattern_gen; border expectations follow VID_PATTERN_BORDER_EN.
module tb_video_pattern_gen;
  localparam int CW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [1:0]    mode;
  logic [23:0]   solid_rgb;
  logic [CW-1:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  logic [7:0]    frame_cnt;

  video_pattern_gen_if #(.DW(DW)) vid ();

  video_pattern_gen #(
    .CW(CW), .DW(DW), .HS_POL(0), .VS_POL(0), .BAR_SHIFT(0), .CHK_SHIFT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .vid(vid), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pos;
  int ht, hsy, hst, hen, vt, vsy, vst, ven;
  int exp_mode, pend_mode;
  logic [23:0] exp_solid, pend_solid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: bar_colour = 24'hFFFFFF;
      1: bar_colour = 24'hFFFF00;
      2: bar_colour = 24'h00FFFF;
      3: bar_colour = 24'h00FF00;
      4: bar_colour = 24'hFF00FF;
      5: bar_colour = 24'hFF0000;
      6: bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int a, b, c, d, e, f, g, h);
    ht = a; hsy = b; hst = c; hen = d; vt = e; vsy = f; vst = g; ven = h;
    h_total = CW'(a); h_sync = CW'(b); h_start = CW'(c); h_end = CW'(d);
    v_total = CW'(e); v_sync = CW'(f); v_start = CW'(g); v_end = CW'(h);
  endtask

  task automatic set_mode(input int m, input logic [23:0] s);
    mode = 2'(m);
    solid_rgb = s;
    pend_mode = m;
    pend_solid = s;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_hs"}, {31'd0, vid.vid_hs}, 32'd1);
    check_eq({tag, "_vs"}, {31'd0, vid.vid_vs}, 32'd1);
    check_eq({tag, "_de"}, {31'd0, vid.vid_de}, 32'd0);
    check_eq({tag, "_sof"}, {31'd0, vid.vid_sof}, 32'd0);
    check_eq({tag, "_rgb"}, {8'd0, vid.vid_r, vid.vid_g, vid.vid_b}, 32'd0);
    check_eq({tag, "_fcnt"}, {24'd0, frame_cnt}, 32'd0);
  endtask

  // Raise en; after two edges the outputs describe raster position 0.
  task automatic start();
    en = 1'b1;
    tick();
    tick();
    pos = 0;
  endtask

  task automatic stop();
    en = 1'b0;
    tick();
  endtask

  // Advance one clock and compare outputs with the expected raster position pos.
  task automatic step(input bit full);
    int len, p, h, v, x, y;
    bit de_e;
    logic [23:0] rgb_e;
    tick();
    len = (ht + 1) * (vt + 1);
    p = pos % len;
    if (p == 0) begin
      exp_mode = pend_mode;
      exp_solid = pend_solid;
    end
    h = p % (ht + 1);
    v = p / (ht + 1);
    x = h - hst;
    y = v - vst;
    de_e = (h >= hst) && (h < hen) && (v >= vst) && (v < ven);
    rgb_e = 24'h0;
    if (de_e) begin
      case (exp_mode)
        0: rgb_e = {3{8'(x)}};
        1: rgb_e = bar_colour(x % 8);
        2: rgb_e = (((x ^ y) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: rgb_e = exp_solid;
      endcase
`ifdef VID_PATTERN_BORDER_EN
      if (x == 0 || y == 0 || x == hen - hst - 1 || y == ven - vst - 1) rgb_e = 24'h0;
`endif
    end
    if (full) begin
      check_eq($sformatf("hs@%0d", pos), {31'd0, vid.vid_hs}, (h < hsy) ? 32'd0 : 32'd1);
      check_eq($sformatf("vs@%0d", pos), {31'd0, vid.vid_vs}, (v < vsy) ? 32'd0 : 32'd1);
      check_eq($sformatf("de@%0d", pos), {31'd0, vid.vid_de}, {31'd0, de_e});
      check_eq($sformatf("rgb@%0d", pos), {8'd0, vid.vid_r, vid.vid_g, vid.vid_b}, {8'd0, rgb_e});
      check_eq($sformatf("sof@%0d", pos), {31'd0, vid.vid_sof},
               (de_e && x == 0 && y == 0) ? 32'd1 : 32'd0);
    end
    check_eq($sformatf("fcnt@%0d", pos), {24'd0, frame_cnt}, ((pos + 1) / len) & 255);
    pos++;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    set_cfg(9, 2, 3, 7, 5, 1, 2, 4);
    set_mode(0, 24'h0);
    exp_mode = 0;
    exp_solid = 24'h0;
    pos = 0;
    repeat (3) tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();
    check_idle("idle_en_low");

    // Grey ramp, then mid-frame switch to solid and to checker.
    start();
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if (i == 150) set_mode(3, 24'h123456);
      if (i == 210) set_mode(2, 24'h123456);
    end

    // Drop en mid-line.
    for (int i = 0; i < 15; i++) step(1'b1);
    stop();
    check_idle("en_drop1");
    tick();
    check_idle("en_drop2");

    // Solid white (border-sensitive), then en low exactly at the frame boundary.
    set_mode(3, 24'hFFFFFF);
    start();
    for (int i = 0; i < 118; i++) step(1'b1);
    stop();
    check_idle("en_vs_boundary");

    // Colour bars on a wider line.
    set_cfg(15, 2, 3, 11, 5, 1, 2, 4);
    set_mode(1, 24'h0);
    start();
    for (int i = 0; i < 96; i++) step(1'b1);
    stop();

    // 256-frame run for frame counter wrap.
    set_cfg(9, 2, 3, 7, 5, 1, 2, 4);
    set_mode(0, 24'h0);
    start();
    for (int i = 0; i < 256 * 60 + 2; i++) step((i < 60) || (i >= 255 * 60));
    stop();

    // Degenerate horizontal window: DE and SOF never assert, syncs still run.
    set_cfg(9, 2, 5, 5, 5, 1, 2, 4);
    start();
    for (int i = 0; i < 120; i++) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
